// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, taken branch, multi-cycle EX and dmem waits.
// Optional stall-cycle counter is built only when HAZARD_STALL_CNT_EN is defined.
module hazard_ctrl #(
    parameter int MULTI_LAT   = 4,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_use_rs1,
    input  logic        ID_use_rs2,
    input  logic [4:0]  EX_rd,
    input  logic        EX_mem_read,
    input  logic        EX_multi,
    input  logic        EX_taken,
    input  logic        MEM_mem_access,
    input  logic        MEM_dmem_ready,
    output logic        pc_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_write,
    output logic        ID_EX_flush,
    output logic        EX_MEM_write,
    output logic        EX_MEM_flush,
    output logic        MEM_WB_flush,
    output logic        busy_multi,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic {RUN, MULTI} state_t;

    localparam bit         MULTI_EN  = (MULTI_LAT > 1);
    localparam logic [3:0] MCNT_LOAD = MULTI_EN ? 4'(MULTI_LAT - 2) : 4'd0;
    localparam logic [7:0] WCNT_MAX  = 8'(MEM_TIMEOUT);

    state_t     state_reg, state_next;
    logic [3:0] mcnt_reg, mcnt_next;
    logic [7:0] wcnt_reg, wcnt_next;
    logic       timeout_reg, timeout_next;
    logic       mem_wait, load_use, multi_start, multi_hold;

    always_comb begin
        mem_wait    = MEM_mem_access && !MEM_dmem_ready;
        load_use    = EX_mem_read && (EX_rd != 5'd0) &&
                      ((ID_use_rs1 && (ID_rs1 == EX_rd)) || (ID_use_rs2 && (ID_rs2 == EX_rd)));
        multi_start = (state_reg == RUN) && EX_multi && MULTI_EN;
        multi_hold  = (state_reg == MULTI) && (mcnt_reg != 4'd0);

        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_write  = 1'b1;
        ID_EX_flush  = 1'b0;
        EX_MEM_write = 1'b1;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;

        state_next   = state_reg;
        mcnt_next    = mcnt_reg;
        wcnt_next    = 8'd0;
        timeout_next = timeout_reg;

        if (!rstn) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            MEM_WB_flush = 1'b1;
        end else if (mem_wait) begin
            // Whole front of the pipe holds; MEM/WB gets a bubble. FSM and mcnt freeze.
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_flush = 1'b1;
            wcnt_next    = (wcnt_reg == WCNT_MAX) ? wcnt_reg : wcnt_reg + 8'd1;
            if (wcnt_next == WCNT_MAX)
                timeout_next = 1'b1;
        end else if (multi_start || multi_hold) begin
            // EX keeps the multi op; EX/MEM receives a bubble each held cycle.
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_flush = 1'b1;
            if (multi_start) begin
                state_next = MULTI;
                mcnt_next  = MCNT_LOAD;
            end else begin
                mcnt_next  = mcnt_reg - 4'd1;
            end
        end else begin
            state_next = RUN;
            if (EX_taken) begin
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                IF_ID_write = 1'b0;
                ID_EX_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg   <= RUN;
            mcnt_reg    <= 4'd0;
            wcnt_reg    <= 8'd0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mcnt_reg    <= mcnt_next;
            wcnt_reg    <= wcnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign busy_multi  = rstn && (state_reg == MULTI);
    assign mem_timeout = rstn && timeout_reg;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rstn)
            stall_cnt_reg <= 32'd0;
        else if (!pc_write)
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end

    assign stall_cycles = rstn ? stall_cnt_reg : 32'd0;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed literal cases plus randomized traffic vs a behavioural model.
// Two instances share inputs: MULTI_LAT=4 and MULTI_LAT=1, both with MEM_TIMEOUT=8.
module tb_hazard_ctrl;

    localparam int TO = 8;
    // Output vector order: pc, IF_ID_w, IF_ID_f, ID_EX_w, ID_EX_f, EX_MEM_w, EX_MEM_f, MEM_WB_f, busy, timeout
    localparam logic [9:0] V_RST  = 10'b0010101100;
    localparam logic [9:0] V_DEF  = 10'b1101010000;
    localparam logic [9:0] V_LU   = 10'b0001110000;
    localparam logic [9:0] V_BR   = 10'b1111110000;
    localparam logic [9:0] V_MUL  = 10'b0000011000;
    localparam logic [9:0] V_WAIT = 10'b0000000100;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] ID_rs1, ID_rs2, EX_rd;
    logic       ID_use_rs1, ID_use_rs2, EX_mem_read, EX_multi, EX_taken;
    logic       MEM_mem_access, MEM_dmem_ready;

    logic [9:0]  vec [2];
    logic [31:0] stl [2];
    logic a_pcw, a_ifw, a_iff, a_idw, a_idf, a_exw, a_exf, a_wbf, a_busy, a_to;
    logic b_pcw, b_ifw, b_iff, b_idw, b_idf, b_exw, b_exf, b_wbf, b_busy, b_to;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULTI_LAT(4), .MEM_TIMEOUT(TO)) ua (
        .clk(clk), .rstn(rstn), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd),
        .EX_mem_read(EX_mem_read), .EX_multi(EX_multi), .EX_taken(EX_taken),
        .MEM_mem_access(MEM_mem_access), .MEM_dmem_ready(MEM_dmem_ready),
        .pc_write(a_pcw), .IF_ID_write(a_ifw), .IF_ID_flush(a_iff),
        .ID_EX_write(a_idw), .ID_EX_flush(a_idf), .EX_MEM_write(a_exw),
        .EX_MEM_flush(a_exf), .MEM_WB_flush(a_wbf), .busy_multi(a_busy),
        .mem_timeout(a_to), .stall_cycles(stl[0]));

    hazard_ctrl #(.MULTI_LAT(1), .MEM_TIMEOUT(TO)) ub (
        .clk(clk), .rstn(rstn), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd),
        .EX_mem_read(EX_mem_read), .EX_multi(EX_multi), .EX_taken(EX_taken),
        .MEM_mem_access(MEM_mem_access), .MEM_dmem_ready(MEM_dmem_ready),
        .pc_write(b_pcw), .IF_ID_write(b_ifw), .IF_ID_flush(b_iff),
        .ID_EX_write(b_idw), .ID_EX_flush(b_idf), .EX_MEM_write(b_exw),
        .EX_MEM_flush(b_exf), .MEM_WB_flush(b_wbf), .busy_multi(b_busy),
        .mem_timeout(b_to), .stall_cycles(stl[1]));

    assign vec[0] = {a_pcw, a_ifw, a_iff, a_idw, a_idf, a_exw, a_exf, a_wbf, a_busy, a_to};
    assign vec[1] = {b_pcw, b_ifw, b_iff, b_idw, b_idf, b_exw, b_exf, b_wbf, b_busy, b_to};

    // Behavioural model: per instance, is a multi op in EX and how many EX cycles it has used.
    int lat [2] = '{4, 1};
    bit in_op [2];
    int done [2];
    int wrun [2];
    bit tflag [2];
    int scnt [2];
    logic [9:0] exp_v [2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got === req)
            n_pass++;
        else
            $display("FAIL %s cycle=%0d: got %h required %h", name, cyc, got, req);
    endtask

    function automatic logic [9:0] model_out(input int k);
        logic [9:0] e;
        bit w, lu;
        int c;
        w  = MEM_mem_access && !MEM_dmem_ready;
        lu = EX_mem_read && (EX_rd != 0) &&
             ((ID_use_rs1 && ID_rs1 == EX_rd) || (ID_use_rs2 && ID_rs2 == EX_rd));
        if (!rstn) return V_RST;
        c = in_op[k] ? done[k] + 1 : 1;
        if (w)
            e = V_WAIT;
        else if ((in_op[k] || (EX_multi && lat[k] > 1)) && c < lat[k])
            e = V_MUL;
        else if (EX_taken)
            e = V_BR;
        else if (lu)
            e = V_LU;
        else
            e = V_DEF;
        e[1] = in_op[k];
        e[0] = tflag[k];
        return e;
    endfunction

    task automatic model_step(input int k);
        bit w;
        int c;
        w = MEM_mem_access && !MEM_dmem_ready;
        if (!rstn) begin
            in_op[k] = 0; done[k] = 0; wrun[k] = 0; tflag[k] = 0; scnt[k] = 0;
        end else begin
            if (exp_v[k][9] == 1'b0) scnt[k]++;
            if (w) begin
                wrun[k]++;
                if (wrun[k] >= TO) tflag[k] = 1;
            end else begin
                wrun[k] = 0;
                if (in_op[k] || (EX_multi && lat[k] > 1)) begin
                    c = in_op[k] ? done[k] + 1 : 1;
                    if (c < lat[k]) begin
                        in_op[k] = 1; done[k] = c;
                    end else begin
                        in_op[k] = 0; done[k] = 0;
                    end
                end
            end
        end
    endtask

    // Inputs are applied 1 time unit after posedge; settle() samples at the falling edge.
    task automatic settle();
        logic [31:0] s_exp;
        #4;
        for (int k = 0; k < 2; k++) begin
            exp_v[k] = model_out(k);
`ifdef HAZARD_STALL_CNT_EN
            s_exp = rstn ? 32'(scnt[k]) : 32'd0;
`else
            s_exp = 32'd0;
`endif
            chk(k == 0 ? "model_outs_lat4" : "model_outs_lat1", {22'd0, vec[k]}, {22'd0, exp_v[k]});
            chk(k == 0 ? "model_stall_lat4" : "model_stall_lat1", stl[k], s_exp);
        end
    endtask

    task automatic advance();
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_use_rs1 = 0; ID_use_rs2 = 0;
        EX_rd = 5'd0; EX_mem_read = 0; EX_multi = 0; EX_taken = 0;
        MEM_mem_access = 0; MEM_dmem_ready = 1;
    endtask

    task automatic lit(input string name, input logic [9:0] got, input logic [9:0] req);
        chk(name, {22'd0, got}, {22'd0, req});
    endtask

    task automatic load_use_hit();
        EX_mem_read = 1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int burst;
        rstn = 0;
        idle();
        @(posedge clk);
        #1;

        settle(); lit("reset", vec[0], V_RST); chk("reset_stall", stl[0], 32'd0); advance();
        settle(); advance();
        rstn = 1;
        settle(); lit("default", vec[0], V_DEF); advance();

        load_use_hit();
        settle(); lit("load_use", vec[0], V_LU); lit("load_use_lat1", vec[1], V_LU); advance();
        EX_rd = 5'd0; ID_rs1 = 5'd0;
        settle(); lit("load_use_x0", vec[0], V_DEF); advance();

        idle(); EX_multi = 1;
        settle(); lit("multi_c1", vec[0], V_MUL); lit("multi_lat1", vec[1], V_DEF); advance();
        settle(); lit("multi_c2", vec[0], V_MUL | 10'b10); advance();
        settle(); lit("multi_c3", vec[0], V_MUL | 10'b10); advance();
        settle(); lit("multi_c4_release", vec[0], V_DEF | 10'b10); advance();
        EX_multi = 0;
        settle(); lit("multi_after", vec[0], V_DEF); advance();

        load_use_hit(); EX_taken = 1;
        settle(); lit("branch_over_lu", vec[0], V_BR); advance();
        idle(); EX_taken = 1; MEM_mem_access = 1; MEM_dmem_ready = 0;
        settle(); lit("branch_in_wait", vec[0], V_WAIT); advance();
        MEM_dmem_ready = 1;
        settle(); lit("branch_after_wait", vec[0], V_BR); advance();

        idle(); MEM_mem_access = 1; MEM_dmem_ready = 0;
        for (int i = 0; i < TO; i++) begin
            settle();
            if (i == TO - 1) lit("timeout_not_yet", vec[0], V_WAIT);
            advance();
        end
        idle();
        settle(); lit("timeout_set", vec[0], V_DEF | 10'b1); advance();
        settle(); lit("timeout_sticky", vec[0], V_DEF | 10'b1); advance();
        rstn = 0;
        settle(); lit("timeout_reset", vec[0], V_RST); advance();
        rstn = 1;
        settle(); lit("timeout_cleared", vec[0], V_DEF); advance();

        EX_multi = 1;
        settle(); lit("mw_c1", vec[0], V_MUL); advance();
        EX_multi = 0; MEM_mem_access = 1; MEM_dmem_ready = 0;
        settle(); lit("mw_wait1", vec[0], V_WAIT | 10'b10); advance();
        settle(); lit("mw_wait2", vec[0], V_WAIT | 10'b10); advance();
        idle();
        settle(); lit("mw_c4", vec[0], V_MUL | 10'b10); advance();
        settle(); lit("mw_c5", vec[0], V_MUL | 10'b10); advance();
        settle(); lit("mw_c6_release", vec[0], V_DEF | 10'b10); advance();
        settle(); lit("mw_after", vec[0], V_DEF); advance();

        EX_multi = 1;
        settle(); advance();
        EX_multi = 0;
        settle(); advance();
        rstn = 0;
        settle(); lit("reset_mid_multi", vec[0], V_RST); advance();
        rstn = 1;
        settle(); lit("after_reset_multi", vec[0], V_DEF); advance();

        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            rstn           = ($urandom_range(0, 149) != 0);
            ID_rs1         = 5'($urandom_range(0, 3));
            ID_rs2         = 5'($urandom_range(0, 3));
            ID_use_rs1     = 1'($urandom_range(0, 1));
            ID_use_rs2     = 1'($urandom_range(0, 1));
            EX_rd          = 5'($urandom_range(0, 3));
            EX_mem_read    = ($urandom_range(0, 2) == 0);
            EX_multi       = ($urandom_range(0, 4) == 0);
            EX_taken       = ($urandom_range(0, 4) == 0);
            if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(5, 12);
            if (burst > 0) begin
                MEM_mem_access = 1; MEM_dmem_ready = 0; burst--;
            end else begin
                MEM_mem_access = 1'($urandom_range(0, 1));
                MEM_dmem_ready = ($urandom_range(0, 3) != 0);
            end
            settle();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
